// File: rtl/fft_frame_ctrl_pkg.sv
// Shared FFT package: default frame geometry and the read-side FSM state encoding.
package fft_frame_ctrl_pkg;

    localparam int DEF_BIT_WIDTH = 16;
    localparam int DEF_N         = 9;
    localparam int DEF_FFT_SIZE  = 512;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_LOAD,
        RD_START,
        RD_WAIT_DONE
    } rd_state_e;

endpackage

// File: rtl/fft_frame_ctrl.sv
// Ping-pong frame controller: fills RAM A/B from a sample stream and replays each
// full frame into an FFT core, dropping (and counting) samples when both are full.
module fft_frame_ctrl
    import fft_frame_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int N         = DEF_N,
    parameter int FFT_SIZE  = DEF_FFT_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [BIT_WIDTH-1:0] sample_in,
    output logic                 we_a,
    output logic                 we_b,
    output logic [N-1:0]         addr_a,
    output logic [N-1:0]         addr_b,
    output logic [BIT_WIDTH-1:0] wr_data,
    input  logic [BIT_WIDTH-1:0] dout_a,
    input  logic [BIT_WIDTH-1:0] dout_b,
    output logic                 fft_load,
    output logic [N-1:0]         fft_add,
    output logic [BIT_WIDTH-1:0] fft_din,
    output logic                 fft_start,
    input  logic                 fft_done,
    input  logic                 ovr_clr,
    output logic                 overrun,
    output logic [15:0]          drop_cnt,
    output logic                 busy,
    output rd_state_e            dbg_state
);

    localparam logic [N-1:0] LAST_IDX = N'(FFT_SIZE - 1);

    rd_state_e      state, state_nxt;
    logic           wr_buf, rd_buf;
    logic [N-1:0]   wr_idx, rd_idx, rd_idx_nxt;
    logic [1:0]     full;
    logic           we_q, we_buf_q, load_q;
    logic [N-1:0]   wr_addr_q;
    logic           accept, drop, frame_done;

    assign accept     = sample_valid && !full[wr_buf];
    assign drop       = sample_valid &&  full[wr_buf];
    assign frame_done = (state == RD_WAIT_DONE) && fft_done;

    // The write is issued one cycle after the sample; its address is latched so
    // wr_idx can already advance for a back-to-back sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_buf    <= 1'b0;
            wr_idx    <= '0;
            we_q      <= 1'b0;
            we_buf_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data   <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                we_buf_q  <= wr_buf;
                wr_addr_q <= wr_idx;
                wr_data   <= sample_in;
                if (wr_idx == LAST_IDX) begin
                    wr_idx <= '0;
                    wr_buf <= ~wr_buf;
                end else begin
                    wr_idx <= wr_idx + N'(1);
                end
            end
        end
    end

    // Set and clear never hit the same bit: a buffer being released is full, so it cannot be written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 2'b00;
        end else begin
            if (accept && (wr_idx == LAST_IDX)) full[wr_buf] <= 1'b1;
            if (frame_done)                     full[rd_buf] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else if (ovr_clr) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt  = state;
        rd_idx_nxt = rd_idx;
        case (state)
            RD_IDLE: begin
                if (full[rd_buf]) begin
                    state_nxt  = RD_LOAD;
                    rd_idx_nxt = '0;
                end
            end
            RD_LOAD: begin
                if (rd_idx == LAST_IDX) begin
                    state_nxt  = RD_START;
                    rd_idx_nxt = '0;
                end else begin
                    rd_idx_nxt = rd_idx + N'(1);
                end
            end
            RD_START:     state_nxt = RD_WAIT_DONE;
            RD_WAIT_DONE: if (fft_done) state_nxt = RD_IDLE;
            default:      state_nxt = RD_IDLE;
        endcase
    end

    // Load strobe/index are delayed one cycle to line up with the synchronous RAM read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RD_IDLE;
            rd_idx    <= '0;
            rd_buf    <= 1'b0;
            load_q    <= 1'b0;
            fft_add   <= '0;
            fft_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_idx    <= rd_idx_nxt;
            load_q    <= (state == RD_LOAD);
            fft_add   <= rd_idx;
            fft_start <= (state == RD_START);
            if (frame_done) rd_buf <= ~rd_buf;
        end
    end

    assign we_a      = we_q && !we_buf_q;
    assign we_b      = we_q &&  we_buf_q;
    assign addr_a    = ((state == RD_LOAD) && !rd_buf) ? rd_idx : wr_addr_q;
    assign addr_b    = ((state == RD_LOAD) &&  rd_buf) ? rd_idx : wr_addr_q;
    assign fft_load  = load_q;
    assign fft_din   = rd_buf ? dout_b : dout_a;
    assign busy      = (state != RD_IDLE);
    assign dbg_state = state;

endmodule
